// File: rtl/palette_lut.sv
// palette_lut: programmable double-banked colour look-up table for the VGA path.
// Maps a pixel colour index to registered {R,G,B} channel outputs (latency 2).
// Two banks are writable at any time; the displayed bank changes only when a
// requested swap meets a frame_start pulse, so a frame never mixes banks.
//
// Ports:
//   clk, rst           pixel clock, asynchronous active-high reset
//   pix_valid_in       color_in carries a live pixel this cycle
//   color_in           palette index
//   blank_in           blanking interval, forces black
//   frame_start        one-cycle start-of-frame pulse
//   wr_en/wr_bank/wr_addr/wr_data   palette write port, word packed {B,G,R}
//   swap_req           request display-bank swap at the next frame_start
//   vga_r/vga_g/vga_b  registered channel outputs
//   pix_valid_out      outputs belong to a valid input pixel
//   disp_bank          bank currently displayed
//   swap_pending       swap requested but not yet taken
module palette_lut #(
  parameter int IDX_W   = 3,
  parameter int COLOR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pix_valid_in,
  input  logic [IDX_W-1:0]     color_in,
  input  logic                 blank_in,
  input  logic                 frame_start,
  input  logic                 wr_en,
  input  logic                 wr_bank,
  input  logic [IDX_W-1:0]     wr_addr,
  input  logic [3*COLOR_W-1:0] wr_data,
  input  logic                 swap_req,
  output logic [COLOR_W-1:0]   vga_r,
  output logic [COLOR_W-1:0]   vga_g,
  output logic [COLOR_W-1:0]   vga_b,
  output logic                 pix_valid_out,
  output logic                 disp_bank,
  output logic                 swap_pending
);

  localparam int unsigned DEPTH  = 1 << IDX_W;
  localparam int unsigned WORD_W = 3 * COLOR_W;
  // Narrow channels keep the MSBs of the 8-bit default; wide ones zero-extend.
  localparam int unsigned SHIFT  = (COLOR_W < 8) ? (8 - COLOR_W) : 0;

  typedef enum logic {S_IDLE, S_PENDING} state_t;

  function automatic logic [WORD_W-1:0] f_default(input int unsigned idx);
    logic [23:0]       w8;
    logic [7:0]        ch;
    logic [WORD_W-1:0] w;
    case (idx)
      0:       w8 = 24'hffffff;
      1:       w8 = 24'h2098dc;
      2:       w8 = 24'h23cee5;
      3:       w8 = 24'h14b5e1;
      4:       w8 = 24'hffffff;
      5:       w8 = 24'h712e23;
      6:       w8 = 24'hdbb369;
      7:       w8 = 24'h205cd0;
      default: w8 = '0;
    endcase
    w = '0;
    for (int unsigned c = 0; c < 3; c++) begin
      ch = w8[c*8 +: 8];
      w[c*COLOR_W +: COLOR_W] = COLOR_W'(ch >> SHIFT);
    end
    return w;
  endfunction

  logic [WORD_W-1:0] r_bank [2][DEPTH];
  logic [IDX_W-1:0]  r_idx;
  logic              r_blank;
  logic              r_valid;
  state_t            r_state;
  logic [WORD_W-1:0] w_word;

  // Reads the pre-edge contents, so a same-cycle write to this entry is seen
  // only by the following lookup.
  assign w_word = r_bank[disp_bank][r_idx];

  // Palette storage: both banks reload the default table on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          r_bank[b][i] <= f_default(i);
        end
      end
    end else if (wr_en) begin
      r_bank[wr_bank][wr_addr] <= wr_data;
    end
  end

  // Stage 1: capture pixel attributes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_blank <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_idx   <= color_in;
      r_blank <= blank_in;
      r_valid <= pix_valid_in;
    end
  end

  // Stage 2: lookup and register channels; black when blanked or not valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_r         <= '0;
      vga_g         <= '0;
      vga_b         <= '0;
      pix_valid_out <= 1'b0;
    end else begin
      pix_valid_out <= r_valid;
      if (r_valid && !r_blank) begin
        vga_r <= w_word[COLOR_W-1:0];
        vga_g <= w_word[2*COLOR_W-1:COLOR_W];
        vga_b <= w_word[3*COLOR_W-1:2*COLOR_W];
      end else begin
        vga_r <= '0;
        vga_g <= '0;
        vga_b <= '0;
      end
    end
  end

  // Swap control: a request arms the swap; only a later frame_start fires it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      disp_bank    <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (swap_req) begin
            r_state      <= S_PENDING;
            swap_pending <= 1'b1;
          end
        end
        S_PENDING: begin
          if (frame_start) begin
            r_state      <= S_IDLE;
            disp_bank    <= ~disp_bank;
            swap_pending <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          swap_pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_palette_lut.sv
// Testbench for palette_lut: directed scenarios plus random traffic, checked by
// a queue-based scoreboard fed from a behavioural palette model.
module tb_palette_lut;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid_in;
  logic [2:0]  color_in;
  logic        blank_in;
  logic        frame_start;
  logic        wr_en;
  logic        wr_bank;
  logic [2:0]  wr_addr;
  logic [23:0] wr_data;
  logic        swap_req;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        pix_valid_out;
  logic        disp_bank;
  logic        swap_pending;

  int total = 0;
  int bad   = 0;

  palette_lut #(.IDX_W(3), .COLOR_W(8)) dut (
    .clk(clk), .rst(rst), .pix_valid_in(pix_valid_in), .color_in(color_in),
    .blank_in(blank_in), .frame_start(frame_start), .wr_en(wr_en),
    .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .swap_req(swap_req), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .pix_valid_out(pix_valid_out), .disp_bank(disp_bank),
    .swap_pending(swap_pending)
  );

  always #5 clk = ~clk;

  // Reference model: palette contents, displayed bank, pending flag and the
  // pixel currently waiting for its lookup.
  logic [23:0] m_bank [2][8];
  logic        m_disp, m_pend;
  logic        m_pv, m_pb;
  logic [2:0]  m_pi;
  logic [23:0] q[$];   // expected {R,G,B} for each valid pixel

  function automatic logic [23:0] dflt(input int i);
    logic [23:0] t [8];
    t = '{24'hffffff, 24'h2098dc, 24'h23cee5, 24'h14b5e1,
          24'hffffff, 24'h712e23, 24'hdbb369, 24'h205cd0};
    return t[i];
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 8; i++) m_bank[b][i] = dflt(i);
    m_disp = 0; m_pend = 0; m_pv = 0; m_pb = 0; m_pi = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per presented valid pixel.
  always @(negedge clk) begin
    if (pix_valid_out === 1'b1) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL pixel: got unexpected valid %h%h%h expected none", vga_r, vga_g, vga_b);
      end else begin
        chk("pixel", {8'h0, vga_r, vga_g, vga_b}, {8'h0, q.pop_front()});
      end
    end else begin
      chk("nonvalid_black", {8'h0, vga_r, vga_g, vga_b}, 32'h0);
    end
  end

  // One clock of stimulus; the model advances exactly as one edge would.
  task automatic cyc(input logic v, input logic [2:0] idx, input logic bl,
                     input logic fs, input logic sr, input logic we,
                     input logic wb, input logic [2:0] wa, input logic [23:0] wd);
    logic [23:0] w;
    @(negedge clk);
    chk("disp_bank", {31'h0, disp_bank}, {31'h0, m_disp});
    chk("swap_pending", {31'h0, swap_pending}, {31'h0, m_pend});
    // Lookup happens at the coming edge, before this cycle's write lands.
    if (m_pv) begin
      w = m_bank[m_disp][m_pi];
      q.push_back(m_pb ? 24'h0 : {w[7:0], w[15:8], w[23:16]});
    end
    pix_valid_in = v; color_in = idx; blank_in = bl; frame_start = fs;
    swap_req = sr; wr_en = we; wr_bank = wb; wr_addr = wa; wr_data = wd;
    m_pv = v; m_pi = idx; m_pb = bl;
    if (we) m_bank[wb][wa] = wd;
    if (m_pend && fs) begin m_disp = ~m_disp; m_pend = 0; end
    else if (!m_pend && sr) m_pend = 1;
  endtask

  task automatic pix(input logic [2:0] idx);
    cyc(1, idx, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    #1;
    chk("reset_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h0);
    chk("reset_valid", {31'h0, pix_valid_out}, 32'h0);
    chk("reset_disp", {31'h0, disp_bank}, 32'h0);
    q.delete();
    model_reset();
    pix_valid_in = 0; frame_start = 0; swap_req = 0; wr_en = 0; blank_in = 0;
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; pix_valid_in = 0; color_in = 0; blank_in = 0; frame_start = 0;
    wr_en = 0; wr_bank = 0; wr_addr = 0; wr_data = 0; swap_req = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;

    // Defaults, blanking and invalid pixels.
    pix(1); pix(2); pix(5);
    cyc(1, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Write bank1[3]; no frame_start -> still default; then swap.
    cyc(0, 0, 0, 0, 0, 1, 1, 3, 24'h00ff00);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    pix(3); idle(2);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
    pix(3); idle(2);

    // Back to bank0, then same-cycle lookup/write collision on entry 6.
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
    pix(6);
    cyc(0, 0, 0, 0, 0, 1, 0, 6, 24'h123456);
    pix(6); idle(2);

    // Double request, single toggle; request coincident with frame_start.
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle(1);
    cyc(0, 0, 0, 1, 1, 0, 0, 0, 0);
    idle(1);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle(1);

    // Reset mid-stream after bank1 writes and a pending swap.
    cyc(1, 3, 0, 0, 0, 1, 1, 3, 24'habcdef);
    cyc(1, 3, 0, 0, 1, 0, 0, 0, 0);
    do_reset();
    pix(3); idle(2);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 3) != 0), 3'($urandom), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 3) == 0), 1'($urandom), 3'($urandom), 24'($urandom));
      if (n == 1500) do_reset();
    end
    idle(3);
    chk("scoreboard_empty", q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
